// File: rtl/tw_rom_sched.sv
// tw_rom_sched: twiddle ROM bank pass sequencer.
// Runs an optional load pass (collect 2*LOAD_WORDS words, then write
// contiguous high-half and low-half bursts), followed by a read pass of
// STAGE_NUM stages x BURSTS bursts of BURST_LEN enabled cycles, each burst
// followed by GAP_LEN idle cycles. hold freezes the read pass; abort returns
// to IDLE with every output at its reset value.
// Optional macro TW_SCHED_PERF_EN builds the CEN-low cycle counter behind
// perf_rd_cycles; without it perf_rd_cycles is tied to zero.
// LOAD_WORDS must be a power of two and at least 2.
module tw_rom_sched #(
    parameter int SC_WIDTH   = 3,
    parameter int S_WIDTH    = 4,
    parameter int DW         = 64,
    parameter int LOAD_WORDS = 4,
    parameter int STAGE_NUM  = 3,
    parameter int BURST_LEN  = 16,
    parameter int BURSTS     = 4,
    parameter int GAP_LEN    = 2
) (
    input  logic                CLK,
    input  logic                rst,
    input  logic                start,
    input  logic                load_req,
    input  logic                hold,
    input  logic                abort,
    input  logic [DW-1:0]       tf_in,
    input  logic                tf_valid,
    output logic                tf_ready,
    output logic [DW-1:0]       horizontal_tf_out,
    output logic [1:0]          ROM7_w,
    output logic [SC_WIDTH-1:0] stage_counter,
    output logic                CEN,
    output logic [S_WIDTH-1:0]  state,
    output logic                busy,
    output logic                done,
    output logic [31:0]         perf_rd_cycles
);

    localparam int CNT_MAX_A = (BURST_LEN > GAP_LEN) ? BURST_LEN : GAP_LEN;
    localparam int CNT_MAX   = (CNT_MAX_A > 2 * LOAD_WORDS) ? CNT_MAX_A : 2 * LOAD_WORDS;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int BST_W     = $clog2(BURSTS + 1);
    localparam int LW_W      = $clog2(LOAD_WORDS);

    localparam logic [CNT_W-1:0]    CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]    CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]    COL_LAST   = CNT_W'(2 * LOAD_WORDS - 1);
    localparam logic [CNT_W-1:0]    WR_LAST    = CNT_W'(LOAD_WORDS - 1);
    localparam logic [CNT_W-1:0]    RD_LAST    = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0]    GAP_LAST   = CNT_W'(GAP_LEN - 1);
    localparam logic [BST_W-1:0]    BST_ZERO   = {BST_W{1'b0}};
    localparam logic [BST_W-1:0]    BST_ONE    = {{(BST_W-1){1'b0}}, 1'b1};
    localparam logic [BST_W-1:0]    BST_LAST   = BST_W'(BURSTS - 1);
    localparam logic [SC_WIDTH-1:0] SC_ZERO    = {SC_WIDTH{1'b0}};
    localparam logic [SC_WIDTH-1:0] SC_ONE     = {{(SC_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SC_WIDTH-1:0] SC_LAST    = SC_WIDTH'(STAGE_NUM - 1);
    localparam logic [S_WIDTH-1:0]  ST_NONE    = S_WIDTH'(4'd0);
    localparam logic [S_WIDTH-1:0]  ST_EVEN    = S_WIDTH'(4'd4);
    localparam logic [S_WIDTH-1:0]  ST_ODD     = S_WIDTH'(4'd6);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_WR_HI   = 3'd2,
        S_WR_LO   = 3'd3,
        S_RD      = 3'd4,
        S_GAP     = 3'd5,
        S_DONE    = 3'd6
    } fsm_t;

    fsm_t                fsm_r, fsm_nx;
    logic [CNT_W-1:0]    cnt_r, cnt_nx;
    logic [BST_W-1:0]    burst_r, burst_nx;
    logic [SC_WIDTH-1:0] stage_r, stage_nx;
    logic                frozen_s;
    logic                accept_s;

    logic [DW-1:0]       hi_r [LOAD_WORDS];
    logic [DW-1:0]       lo_r [LOAD_WORDS];

    logic                tf_ready_r, tf_ready_nx;
    logic [DW-1:0]       hout_r, hout_nx;
    logic [1:0]          rom7_w_r, rom7_w_nx;
    logic                cen_r, cen_nx;
    logic [S_WIDTH-1:0]  state_r, state_nx;
    logic                busy_r, busy_nx;
    logic                done_r, done_nx;

    // Next-state and counter sequencing; abort overrides everything.
    always_comb begin
        fsm_nx   = fsm_r;
        cnt_nx   = cnt_r;
        burst_nx = burst_r;
        stage_nx = stage_r;
        frozen_s = 1'b0;
        accept_s = 1'b0;
        if (abort) begin
            fsm_nx   = S_IDLE;
            cnt_nx   = CNT_ZERO;
            burst_nx = BST_ZERO;
            stage_nx = SC_ZERO;
        end else begin
            case (fsm_r)
                S_IDLE: begin
                    cnt_nx   = CNT_ZERO;
                    burst_nx = BST_ZERO;
                    stage_nx = SC_ZERO;
                    if (start) begin
                        fsm_nx = load_req ? S_COLLECT : S_RD;
                    end else begin
                        fsm_nx = S_IDLE;
                    end
                end
                S_COLLECT: begin
                    accept_s = tf_valid & tf_ready_r;
                    if (accept_s && (cnt_r == COL_LAST)) begin
                        fsm_nx = S_WR_HI;
                        cnt_nx = CNT_ZERO;
                    end else if (accept_s) begin
                        cnt_nx = cnt_r + CNT_ONE;
                    end else begin
                        cnt_nx = cnt_r;
                    end
                end
                S_WR_HI: begin
                    if (cnt_r == WR_LAST) begin
                        fsm_nx = S_WR_LO;
                        cnt_nx = CNT_ZERO;
                    end else begin
                        cnt_nx = cnt_r + CNT_ONE;
                    end
                end
                S_WR_LO: begin
                    if (cnt_r == WR_LAST) begin
                        fsm_nx   = S_RD;
                        cnt_nx   = CNT_ZERO;
                        burst_nx = BST_ZERO;
                        stage_nx = SC_ZERO;
                    end else begin
                        cnt_nx = cnt_r + CNT_ONE;
                    end
                end
                S_RD: begin
                    if (hold) begin
                        frozen_s = 1'b1;
                    end else if (cnt_r == RD_LAST) begin
                        fsm_nx = S_GAP;
                        cnt_nx = CNT_ZERO;
                    end else begin
                        cnt_nx = cnt_r + CNT_ONE;
                    end
                end
                S_GAP: begin
                    if (hold) begin
                        frozen_s = 1'b1;
                    end else if (cnt_r != GAP_LAST) begin
                        cnt_nx = cnt_r + CNT_ONE;
                    end else if (burst_r != BST_LAST) begin
                        fsm_nx   = S_RD;
                        cnt_nx   = CNT_ZERO;
                        burst_nx = burst_r + BST_ONE;
                    end else if (stage_r != SC_LAST) begin
                        fsm_nx   = S_RD;
                        cnt_nx   = CNT_ZERO;
                        burst_nx = BST_ZERO;
                        stage_nx = stage_r + SC_ONE;
                    end else begin
                        fsm_nx   = S_DONE;
                        cnt_nx   = CNT_ZERO;
                        burst_nx = BST_ZERO;
                        stage_nx = SC_ZERO;
                    end
                end
                S_DONE: begin
                    fsm_nx = S_IDLE;
                end
                default: begin
                    fsm_nx   = S_IDLE;
                    cnt_nx   = CNT_ZERO;
                    burst_nx = BST_ZERO;
                    stage_nx = SC_ZERO;
                end
            endcase
        end
    end

    // Output values for the coming cycle, decoded from the next state.
    always_comb begin
        tf_ready_nx = (fsm_nx == S_COLLECT);
        busy_nx     = (fsm_nx != S_IDLE);
        done_nx     = (fsm_nx == S_DONE);
        rom7_w_nx   = 2'd0;
        hout_nx     = {DW{1'b0}};
        cen_nx      = 1'b1;
        state_nx    = ST_NONE;
        case (fsm_nx)
            S_WR_HI: begin
                rom7_w_nx = 2'd1;
                hout_nx   = hi_r[cnt_nx[LW_W-1:0]];
            end
            S_WR_LO: begin
                rom7_w_nx = 2'd2;
                hout_nx   = lo_r[cnt_nx[LW_W-1:0]];
            end
            default: begin
                rom7_w_nx = 2'd0;
                hout_nx   = {DW{1'b0}};
            end
        endcase
        if (frozen_s) begin
            cen_nx   = 1'b1;
            state_nx = state_r;
        end else if (fsm_nx == S_RD) begin
            cen_nx   = 1'b0;
            state_nx = burst_nx[0] ? ST_ODD : ST_EVEN;
        end else begin
            cen_nx   = 1'b1;
            state_nx = ST_NONE;
        end
    end

    // FSM, counters and registered outputs.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            fsm_r      <= S_IDLE;
            cnt_r      <= CNT_ZERO;
            burst_r    <= BST_ZERO;
            stage_r    <= SC_ZERO;
            tf_ready_r <= 1'b0;
            hout_r     <= {DW{1'b0}};
            rom7_w_r   <= 2'd0;
            cen_r      <= 1'b1;
            state_r    <= ST_NONE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            fsm_r      <= fsm_nx;
            cnt_r      <= cnt_nx;
            burst_r    <= burst_nx;
            stage_r    <= stage_nx;
            tf_ready_r <= tf_ready_nx;
            hout_r     <= hout_nx;
            rom7_w_r   <= rom7_w_nx;
            cen_r      <= cen_nx;
            state_r    <= state_nx;
            busy_r     <= busy_nx;
            done_r     <= done_nx;
        end
    end

    // Collect buffer: even accepts fill hi[], odd accepts fill lo[]; abort discards it.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LOAD_WORDS; i++) begin
                hi_r[i] <= {DW{1'b0}};
                lo_r[i] <= {DW{1'b0}};
            end
        end else if (abort) begin
            for (int i = 0; i < LOAD_WORDS; i++) begin
                hi_r[i] <= {DW{1'b0}};
                lo_r[i] <= {DW{1'b0}};
            end
        end else if (accept_s && cnt_r[0]) begin
            lo_r[cnt_r[LW_W:1]] <= tf_in;
        end else if (accept_s) begin
            hi_r[cnt_r[LW_W:1]] <= tf_in;
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

    assign tf_ready          = tf_ready_r;
    assign horizontal_tf_out = hout_r;
    assign ROM7_w            = rom7_w_r;
    assign stage_counter     = stage_r;
    assign CEN               = cen_r;
    assign state             = state_r;
    assign busy              = busy_r;
    assign done              = done_r;

`ifdef TW_SCHED_PERF_EN
    logic [31:0] perf_r;
    logic        start_acc_s;

    assign start_acc_s = (fsm_r == S_IDLE) & start & ~abort;

    // Saturating count of CEN-low cycles; restarts with each accepted start.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            perf_r <= 32'd0;
        end else if (abort) begin
            perf_r <= 32'd0;
        end else if (start_acc_s) begin
            perf_r <= {31'd0, ~cen_nx};
        end else if (!cen_nx && (perf_r != 32'hFFFF_FFFF)) begin
            perf_r <= perf_r + 32'd1;
        end else begin
            perf_r <= perf_r;
        end
    end

    assign perf_rd_cycles = perf_r;
`else
    assign perf_rd_cycles = 32'd0;
`endif

endmodule

// File: doc/tw_rom_sched.md
Name: tw_rom_sched

Overview:
- Controller for the radix-16 twiddle ROM bank. It sequences one full FFT twiddle pass.
- Optional load pass: collects replacement stage-0 twiddle words from an upstream source through a valid/ready handshake, then writes them into the ROM as contiguous high-half and low-half bursts.
- Read pass: drives stage_counter, CEN and state through per-stage read bursts so the ROM presents twiddles to the butterfly datapath.
- Sits between the FFT top-level sequencer (start/done) and the twiddle ROM.

Parameters:
- SC_WIDTH, 3, width of stage_counter.
- S_WIDTH, 4, width of state.
- DW, 64, half-word width of the twiddle load path.
- LOAD_WORDS, 4, entries rewritten per load pass; each entry is 2 DW words.
- STAGE_NUM, 3, stages sequenced per pass.
- BURST_LEN, 16, read cycles per burst (CEN low).
- BURSTS, 4, bursts per stage.
- GAP_LEN, 2, idle cycles (CEN high) after every burst.

Ports:
- CLK  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  pulse; begins a pass when in IDLE; ignored otherwise.
- load_req  input  1  sampled with start; 1 = run the load pass before reading.
- hold  input  1  datapath stall; freezes the read pass.
- abort  input  1  return to IDLE.
- tf_in  input  DW  upstream twiddle word. Order is hi0, lo0, hi1, lo1, and so on.
- tf_valid  input  1  tf_in valid.
- tf_ready  output  1  block accepts tf_in.
- horizontal_tf_out  output  DW  word to the ROM write port.
- ROM7_w  output  2  ROM write select: 1 = high half, 2 = low half, 0 = none.
- stage_counter  output  SC_WIDTH  current stage.
- CEN  output  1  ROM enable, active-low.
- state  output  S_WIDTH  ROM read-phase code.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse at end of pass.
- perf_rd_cycles  output  32  see Optional Feature.

Behaviour:
- All outputs are registered. Reset values: tf_ready=0, horizontal_tf_out=0, ROM7_w=0, stage_counter=0, CEN=1, state=0, busy=0, done=0, perf_rd_cycles=0.
- FSM states: IDLE, COLLECT, WR_HI, WR_LO, RD, GAP, DONE.
- IDLE:
  - start with load_req=1 -> COLLECT.
  - start with load_req=0 -> RD.
  - The new state's outputs appear on the cycle after start.
- COLLECT:
  - tf_ready=1. A word is accepted on each cycle with tf_valid & tf_ready.
  - Accepted words go into a 2*LOAD_WORDS x DW buffer: even index -> hi[i], odd index -> lo[i].
  - After the 2*LOAD_WORDS-th accept, tf_ready=0 on the next cycle and the FSM moves to WR_HI.
  - Gaps in tf_valid stall COLLECT indefinitely.
- WR_HI: exactly LOAD_WORDS consecutive cycles, ROM7_w=1, horizontal_tf_out=hi[0..LOAD_WORDS-1] in order.
- WR_LO: follows WR_HI with no gap. Exactly LOAD_WORDS cycles, ROM7_w=2, horizontal_tf_out=lo[0..LOAD_WORDS-1]. Then ROM7_w=0 and the FSM moves to RD.
- Write bursts are never interrupted, because the ROM's write index resets whenever ROM7_w=0. hold is ignored during WR_HI/WR_LO.
- RD:
  - CEN=0 for BURST_LEN cycles.
  - state=4 on even-numbered bursts and 6 on odd-numbered bursts; burst index resets to 0 at each new stage.
- GAP: after every burst, CEN=1 and state=0 for GAP_LEN cycles.
- Stage advance: after the last GAP of burst BURSTS-1, stage_counter increments.
- End of pass: after the last GAP of stage STAGE_NUM-1, the FSM enters DONE. done=1 for 1 cycle, stage_counter=0, then IDLE.
- Pass length without load: STAGE_NUM*BURSTS*(BURST_LEN+GAP_LEN) cycles from the first RD cycle to DONE.
- hold (RD/GAP only):
  - While hold=1: CEN=1, all counters frozen, state and stage_counter held.
  - When hold drops, the pass resumes at the same cycle position; a frozen RD burst resumes with CEN=0 and the remaining count.
- abort (any state): next cycle IDLE with all outputs at reset values. The collect buffer content is discarded. abort has priority over hold and start.
- start while busy: ignored. start and abort in the same cycle: abort wins.
- rst mid-pass: immediate return to reset values.

Optional Feature:
- Macro: TW_SCHED_PERF_EN.
- Defined: perf_rd_cycles counts cycles with CEN=0. It clears on accepted start and saturates at 2^32-1.
- Undefined: the counter is not built and perf_rd_cycles is tied to 0.

Test Plan:
- Reset, then start with load_req=0 -> first RD cycle 1 clk after start. Observe 16 CEN-low cycles (state=4), 2 gap cycles, 16 cycles (state=6), and so on. stage_counter steps 0->1->2. done pulses once, 217 cycles after start.
- start with load_req=1, 8 words 0x1..0x8 sent with tf_valid low every other cycle -> ROM7_w=1 for 4 contiguous cycles with outputs 0x1,0x3,0x5,0x7, then ROM7_w=2 for 4 cycles with outputs 0x2,0x4,0x6,0x8, then RD.
- hold=1 for 5 cycles at the 7th cycle of stage-1 burst 2 -> CEN=1 and state frozen during hold. Burst resumes with 10 remaining CEN-low cycles. done is delayed by exactly 5 cycles.
- abort during WR_LO -> next cycle ROM7_w=0, busy=0. A following start with load_req=0 runs a clean pass from stage 0.
- start pulses while busy, plus start and abort asserted together -> no restart. Asserting rst mid-RD gives CEN=1 and stage_counter=0 immediately.
- With TW_SCHED_PERF_EN defined, a full no-load pass -> perf_rd_cycles=192. Without the macro -> 0.
